// File: rtl/lcd_hd44780_peripheral.sv
// lcd_hd44780_peripheral
// Bus responder that drives an 8-bit, write-only HD44780 character LCD.
// A write to DATA (RS=1) or CMD (RS=0) starts a hardware-timed sequence:
// RS/DB setup, E pulse, hold, then the controller execution delay.
// Completion is reported through STAT.busy and a one-cycle irq_strobe.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transfer in flight; DATA/CMD writes are accepted here only
// SETUP | RS/DB driven, waiting T_SETUP cycles before raising E
// EHIGH | E high for T_EHIGH cycles
// HOLD  | E low again, RS/DB held for T_HOLD cycles
// EXEC  | controller busy executing (T_EXEC or T_EXEC_LONG cycles)
module lcd_hd44780_peripheral #(
  parameter logic [8:0]  DATA_ADDR   = 9'h01E,
  parameter logic [8:0]  CMD_ADDR    = 9'h01F,
  parameter logic [8:0]  STAT_ADDR   = 9'h09E,
  parameter int unsigned T_SETUP     = 3,
  parameter int unsigned T_EHIGH     = 12,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_EXEC      = 2000,
  parameter int unsigned T_EXEC_LONG = 80000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] addr,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       sel,
  output logic       irq_strobe,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_EHIGH = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;

  // Counter reload values; every phase counts down to zero inclusive,
  // so a phase of T cycles loads T-1.
  localparam logic [16:0] LD_SETUP     = 17'(T_SETUP - 1);
  localparam logic [16:0] LD_EHIGH     = 17'(T_EHIGH - 1);
  localparam logic [16:0] LD_HOLD      = 17'(T_HOLD - 1);
  localparam logic [16:0] LD_EXEC      = 17'(T_EXEC - 1);
  localparam logic [16:0] LD_EXEC_LONG = 17'(T_EXEC_LONG - 1);

  logic [2:0]  state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic        lcd_e_q, lcd_e_d;
  logic        long_q, long_d;
  logic [7:0]  data_reg_q, data_reg_d;
  logic [7:0]  cmd_reg_q, cmd_reg_d;
  logic [7:0]  lcd_data_q, lcd_data_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic        overrun_q, overrun_d;

  logic hit_data, hit_cmd, hit_stat;
  logic wr_data, wr_cmd, wr_stat;
  logic busy, accept, cnt_zero;

  // Address decode and write qualification
  always_comb begin
    hit_data = (addr == DATA_ADDR);
    hit_cmd  = (addr == CMD_ADDR);
    hit_stat = (addr == STAT_ADDR);
    wr_data  = wr_en & hit_data;
    wr_cmd   = wr_en & hit_cmd;
    wr_stat  = wr_en & hit_stat;
    busy     = (state_q != S_IDLE);
    // The final EXEC cycle still counts as busy, so a write landing on
    // the irq_strobe cycle is rejected as an overrun.
    accept   = (wr_data | wr_cmd) & ~busy;
    cnt_zero = (cnt_q == 17'd0);
  end

  // Zero-latency read mux and select
  always_comb begin
    sel      = hit_data | hit_cmd | hit_stat;
    data_out = 8'h00;
    if (hit_data)      data_out = data_reg_q;
    else if (hit_cmd)  data_out = cmd_reg_q;
    else if (hit_stat) data_out = {6'b0, overrun_q, busy};
  end

  // Register file next-state: DATA/CMD shadows, LCD bus latches, overrun
  always_comb begin
    data_reg_d = data_reg_q;
    cmd_reg_d  = cmd_reg_q;
    lcd_data_d = lcd_data_q;
    lcd_rs_d   = lcd_rs_q;
    overrun_d  = overrun_q;
    if (accept) begin
      lcd_data_d = data_in;
      lcd_rs_d   = wr_data;
      if (wr_data) data_reg_d = data_in;
      else         cmd_reg_d  = data_in;
    end
    if ((wr_data | wr_cmd) & busy) begin
      overrun_d = 1'b1;
    end else if (wr_stat && !data_in[1]) begin
      overrun_d = 1'b0;
    end
  end

  // Sequencer next-state: one shared down-counter times every phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lcd_e_d = lcd_e_q;
    long_d  = long_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Clear display (0x01) and return home (0x02/0x03) need the long wait.
          long_d  = wr_cmd & (data_in[7:2] == 6'd0);
          cnt_d   = LD_SETUP;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          lcd_e_d = 1'b1;
          cnt_d   = LD_EHIGH;
          state_d = S_EHIGH;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      S_EHIGH: begin
        if (cnt_zero) begin
          lcd_e_d = 1'b0;
          cnt_d   = LD_HOLD;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          cnt_d   = long_q ? LD_EXEC_LONG : LD_EXEC;
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      S_EXEC: begin
        if (cnt_zero) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 17'd0;
        lcd_e_d = 1'b0;
      end
    endcase
  end

  // Sequencer state registers; reset drops E asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 17'd0;
      lcd_e_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lcd_e_q <= lcd_e_d;
      long_q  <= long_d;
    end
  end

  // Register file and LCD bus registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg_q <= 8'h00;
      cmd_reg_q  <= 8'h00;
      lcd_data_q <= 8'h00;
      lcd_rs_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      data_reg_q <= data_reg_d;
      cmd_reg_q  <= cmd_reg_d;
      lcd_data_q <= lcd_data_d;
      lcd_rs_q   <= lcd_rs_d;
      overrun_q  <= overrun_d;
    end
  end

  // Output drive; irq is the last EXEC cycle, so reset can never emit it
  always_comb begin
    irq_strobe = (state_q == S_EXEC) && cnt_zero;
    lcd_data   = lcd_data_q;
    lcd_rs     = lcd_rs_q;
    lcd_rw     = 1'b0;
    lcd_e      = lcd_e_q;
  end

endmodule

// File: tb/tb_lcd_hd44780_peripheral.sv
// Directed bench for lcd_hd44780_peripheral with short timing overrides.
// Inputs change on the falling edge; outputs are sampled just after it.
// "Cycle N+k" is the clock period following rising edge N+k-1, where N
// is the edge that accepts the write.
module tb_lcd_hd44780_peripheral;

  localparam logic [8:0] DATA_A = 9'h01E;
  localparam logic [8:0] CMD_A  = 9'h01F;
  localparam logic [8:0] STAT_A = 9'h09E;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] addr = 9'h000;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       sel, irq_strobe, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;

  int n_checks = 0;
  int n_errors = 0;

  lcd_hd44780_peripheral #(
    .T_SETUP(2), .T_EHIGH(4), .T_HOLD(1), .T_EXEC(10), .T_EXEC_LONG(50)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .data_in(data_in),
    .data_out(data_out), .sel(sel), .irq_strobe(irq_strobe),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; the write is taken at the next rising edge
  // and the task returns just after the following falling edge (cycle N+1).
  task automatic bus_write(input logic [8:0] a, input logic [7:0] d);
    addr = a; data_in = d; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic bus_read(input logic [8:0] a, output logic [7:0] d);
    addr = a; #1;
    d = data_out;
  endtask

  task automatic next_cycle();
    @(negedge clk); #1;
  endtask

  // Counts cycles from the current one (numbered `start`) until irq_strobe,
  // giving -1 if it does not appear within the budget.
  task automatic wait_irq(input int start, input int budget, output int at);
    at = -1;
    for (int k = start; k < start + budget; k++) begin
      if (irq_strobe) begin
        at = k;
        break;
      end
      next_cycle();
    end
  endtask

  logic [7:0] rd;
  int at;
  int irq_cnt;

  initial begin
    // 1. Reset
    repeat (2) @(negedge clk);
    #1;
    bus_read(STAT_A, rd);
    check_eq("rst_stat", rd, 8'h00);
    check_eq("rst_lcd_e", lcd_e, 1'b0);
    check_eq("rst_lcd_rw", lcd_rw, 1'b0);
    check_eq("rst_irq", irq_strobe, 1'b0);
    check_eq("rst_lcd_data", lcd_data, 8'h00);
    addr = 9'h000; #1;
    check_eq("rst_sel_none", sel, 1'b0);
    check_eq("rst_dout_none", data_out, 8'h00);
    addr = STAT_A; #1;
    check_eq("sel_stat", sel, 1'b1);
    rst = 1'b0;
    next_cycle();

    // 2. Data write: E high in cycles 3..6, irq in 17, busy through 17
    bus_write(DATA_A, 8'h41);
    addr = STAT_A; #1;
    for (int k = 1; k <= 20; k++) begin
      check_eq($sformatf("dw_e_c%0d", k), lcd_e, (k >= 3 && k <= 6));
      check_eq($sformatf("dw_irq_c%0d", k), irq_strobe, (k == 17));
      check_eq($sformatf("dw_stat_c%0d", k), data_out, (k <= 17) ? 8'h01 : 8'h00);
      check_eq($sformatf("dw_rs_c%0d", k), lcd_rs, 1'b1);
      check_eq($sformatf("dw_db_c%0d", k), lcd_data, 8'h41);
      next_cycle();
    end
    bus_read(DATA_A, rd);
    check_eq("dw_readback", rd, 8'h41);

    // 3. Long command (clear) then normal command (function set)
    bus_write(CMD_A, 8'h01);
    check_eq("lc_rs", lcd_rs, 1'b0);
    check_eq("lc_db", lcd_data, 8'h01);
    wait_irq(1, 100, at);
    check_eq("lc_irq_cycle", at, 57);
    next_cycle();
    bus_read(STAT_A, rd);
    check_eq("lc_stat_after", rd, 8'h00);
    bus_write(CMD_A, 8'h38);
    wait_irq(1, 100, at);
    check_eq("nc_irq_cycle", at, 17);
    next_cycle();
    bus_read(CMD_A, rd);
    check_eq("nc_readback", rd, 8'h38);
    bus_write(CMD_A, 8'h03);
    wait_irq(1, 100, at);
    check_eq("home3_irq_cycle", at, 57);
    next_cycle();
    bus_write(CMD_A, 8'h04);
    wait_irq(1, 100, at);
    check_eq("cmd04_irq_cycle", at, 17);
    next_cycle();

    // 4. Overrun: second DATA write at edge N+5 is dropped
    bus_write(DATA_A, 8'h41);
    repeat (4) next_cycle();
    bus_write(DATA_A, 8'h42);
    check_eq("ov_db", lcd_data, 8'h41);
    bus_read(DATA_A, rd);
    check_eq("ov_readback", rd, 8'h41);
    bus_read(STAT_A, rd);
    check_eq("ov_stat_busy", rd, 8'h03);
    wait_irq(6, 100, at);
    check_eq("ov_irq_cycle", at, 17);
    next_cycle();
    bus_read(STAT_A, rd);
    check_eq("ov_stat_done", rd, 8'h02);
    bus_write(STAT_A, 8'h02);
    bus_read(STAT_A, rd);
    check_eq("ov_stat_keep", rd, 8'h02);
    bus_write(STAT_A, 8'h00);
    bus_read(STAT_A, rd);
    check_eq("ov_stat_clr", rd, 8'h00);

    // 5. Boundary: write on the irq cycle rejected, next cycle accepted
    bus_write(DATA_A, 8'h55);
    wait_irq(1, 100, at);
    check_eq("bd_irq_cycle", at, 17);
    bus_write(DATA_A, 8'h66);
    bus_read(STAT_A, rd);
    check_eq("bd_stat_rej", rd, 8'h02);
    check_eq("bd_db_rej", lcd_data, 8'h55);
    bus_write(DATA_A, 8'h77);
    check_eq("bd_db_acc", lcd_data, 8'h77);
    bus_read(STAT_A, rd);
    check_eq("bd_stat_acc", rd, 8'h03);
    wait_irq(1, 100, at);
    check_eq("bd_irq2_cycle", at, 17);
    next_cycle();
    bus_write(STAT_A, 8'h00);

    // 6. Reset while E is high
    bus_write(DATA_A, 8'h5A);
    next_cycle();
    next_cycle();
    check_eq("mr_e_high", lcd_e, 1'b1);
    rst = 1'b1; #1;
    check_eq("mr_e_drop", lcd_e, 1'b0);
    next_cycle();
    rst = 1'b0;
    irq_cnt = 0;
    for (int k = 0; k < 70; k++) begin
      if (irq_strobe) irq_cnt++;
      next_cycle();
    end
    check_eq("mr_no_irq", irq_cnt, 0);
    bus_read(STAT_A, rd);
    check_eq("mr_stat", rd, 8'h00);
    check_eq("mr_db", lcd_data, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
